// File: rtl/spi_gphy_master.sv
// rtl/spi_gphy_master.sv - SPI master driving the GPHY control slave (40-bit write, 8+32-bit read)
//
// Ports:
//   clk    in   system clock, same domain as the slave
//   rst    in   asynchronous active-low reset
//   start  in   1-cycle request, sampled only in IDLE
//   rw     in   1=write, 0=read, captured with start
//   addr   in   [6:0] slave address, captured with start
//   wdata  in   [31:0] write data, captured with start
//   busy   out  high from the cycle after start until done
//   done   out  1-cycle pulse once cs has been idle for CS_IDLE cycles
//   rdata  out  [31:0] read result, updated only at done of a read
//   sclk   out  SPI clock, idles low, slave samples on rising edge
//   mosi   out  SPI data out, MSB first
//   cs     out  chip select, active low
//   miso   in   SPI data in, reads 1 when the slave is not addressed
module spi_gphy_master #(
    parameter int CLK_DIV = 8,
    parameter int GAP     = 8,
    parameter int CS_IDLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        mosi,
    output logic        cs,
    input  logic        miso
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;
    localparam logic [2:0] S_CSIDLE = 3'd7;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
    localparam logic [15:0] IDLE_LAST = 16'(CS_IDLE - 1);

    logic [2:0]  state;
    logic [15:0] div;       // shared by half-bit timing, GAP and CS idle timing
    logic [5:0]  bitcnt;
    logic [39:0] shreg;     // {rw, addr, wdata}; bit 39 is the bit currently on mosi
    logic [31:0] rdata_sh;
    logic        rw_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            div      <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            rdata_sh <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cs     <= 1'b1;
                    sclk   <= 1'b0;
                    mosi   <= 1'b0;
                    div    <= '0;
                    bitcnt <= '0;
                    if (start) begin
                        shreg <= {rw, addr, wdata};
                        rw_q  <= rw;
                        busy  <= 1'b1;
                        cs    <= 1'b0;
                        mosi  <= rw;    // header bit 7 is valid for the whole setup time
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        state <= S_ADDR;
                    end else begin
                        div <= div + 16'd1;
                    end
                end

                // Header and write data share the same bit timing: low half, then high half.
                // The next bit is loaded onto mosi together with the falling sclk edge.
                S_ADDR, S_WDATA: begin
                    if (div != DIV_LAST) begin
                        div <= div + 16'd1;
                    end else begin
                        div <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (state == S_ADDR && bitcnt == 6'd7 && !rw_q) begin
                            // Read: sclk stays high through GAP so the slave can decode.
                            mosi   <= 1'b0;
                            bitcnt <= '0;
                            state  <= S_GAP;
                        end else if (state == S_WDATA && bitcnt == 6'd31) begin
                            sclk   <= 1'b0;
                            mosi   <= 1'b0;
                            bitcnt <= '0;
                            state  <= S_HOLD;
                        end else begin
                            sclk  <= 1'b0;
                            mosi  <= shreg[38];
                            shreg <= {shreg[38:0], 1'b0};
                            if (state == S_ADDR && bitcnt == 6'd7) begin
                                bitcnt <= '0;
                                state  <= S_WDATA;
                            end else begin
                                bitcnt <= bitcnt + 6'd1;
                            end
                        end
                    end
                end

                // First read bit is already on miso by the end of GAP; it shifts up to
                // bit 31 after the remaining 31 samples.
                S_GAP: begin
                    if (div == GAP_LAST) begin
                        div      <= '0;
                        rdata_sh <= {rdata_sh[30:0], miso};
                        sclk     <= 1'b0;
                        state    <= S_RDATA;
                    end else begin
                        div <= div + 16'd1;
                    end
                end

                S_RDATA: begin
                    if (div != DIV_LAST) begin
                        div <= div + 16'd1;
                    end else begin
                        div <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            rdata_sh <= {rdata_sh[30:0], miso};
                            sclk     <= 1'b0;
                            if (bitcnt == 6'd30) begin
                                bitcnt <= '0;
                                state  <= S_HOLD;
                            end else begin
                                bitcnt <= bitcnt + 6'd1;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (div == DIV_LAST) begin
                        div   <= '0;
                        cs    <= 1'b1;
                        state <= S_CSIDLE;
                    end else begin
                        div <= div + 16'd1;
                    end
                end

                S_CSIDLE: begin
                    if (div == IDLE_LAST) begin
                        div  <= '0;
                        done <= 1'b1;
                        busy <= 1'b0;
                        if (!rw_q) begin
                            rdata <= rdata_sh;
                        end
                        state <= S_IDLE;
                    end else begin
                        div <= div + 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_gphy_master.sv
// tb/tb_spi_gphy_master.sv - scoreboard bench for spi_gphy_master with a behavioural GPHY slave
module tb_spi_gphy_master;

    localparam int D   = 8;
    localparam int G   = 8;
    localparam int CSI = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rw_i = 1'b0;
    logic [6:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        busy, done, sclk, mosi, cs, miso;
    logic [31:0] rdata;

    spi_gphy_master #(.CLK_DIV(D), .GAP(G), .CS_IDLE(CSI)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw_i), .addr(addr_i), .wdata(wdata_i),
        .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural slave (samples on negedge, away from DUT updates)
    logic        st_tx_ready = 0, st_rx_ready = 0, st_pll = 0;
    logic [1:0]  st_rd = 0, st_de = 0, st_ed = 0, st_dk = 0;
    logic [15:0] st_rxd = 0;

    logic        sclk_q = 1'b0, cs_q = 1'b1;
    int          sl_cnt = 0;
    logic [39:0] sl_sh = '0;
    logic [7:0]  sl_hdr = '0;
    logic        sl_sel = 1'b0;
    logic [31:0] sl_out = '0;
    logic [15:0] sl_txd = '0;
    logic [1:0]  sl_txk = '0;
    logic        sl_rphy = 1'b0;

    assign miso = (!cs && sl_sel) ? sl_out[31] : 1'b1;

    always @(negedge clk) begin
        sclk_q <= sclk;
        cs_q   <= cs;
        if (cs_q && !cs) begin
            sl_cnt <= 0;
            sl_sel <= 1'b0;
        end else if (!cs && sclk && !sclk_q) begin
            sl_sh  <= {sl_sh[38:0], mosi};
            sl_cnt <= sl_cnt + 1;
            if (sl_cnt == 7) begin
                sl_hdr <= {sl_sh[6:0], mosi};
                if (!sl_sh[6] && {sl_sh[5:0], mosi} == 7'd1) begin
                    sl_sel <= 1'b1;
                    sl_out <= {5'h0, st_tx_ready, st_rx_ready, st_pll, st_rd, st_de, st_ed, st_dk, st_rxd};
                end
            end
        end else if (!cs && !sclk && sclk_q && sl_sel) begin
            sl_out <= {sl_out[30:0], 1'b1};
        end
        if (!cs_q && cs) begin
            sl_sel <= 1'b0;
            if (sl_cnt == 40 && sl_sh[39:32] == 8'h81) begin
                sl_txd  <= sl_sh[15:0];
                sl_txk  <= sl_sh[17:16];
                sl_rphy <= sl_sh[18];
            end
        end
    end

    // ---------------- cs idle-time watcher
    int  hi_cnt = 0;
    bit  seen_txn = 0;
    always @(negedge clk) begin
        if (cs === 1'b1) begin
            hi_cnt++;
        end else begin
            if (hi_cnt > 0 && seen_txn) begin
                checks++;
                if (hi_cnt < CSI) begin
                    errors++;
                    $display("FAIL cs_idle: got %0d cycles expected >= %0d", hi_cnt, CSI);
                end
            end
            if (hi_cnt > 0) seen_txn = 1;
            hi_cnt = 0;
        end
    end

    // ---------------- reference model + scoreboard
    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          edges;
        logic [7:0]  hdr;
        logic [15:0] txd;
        logic [1:0]  txk;
        logic        rphy;
        int          t0;
    } exp_t;

    exp_t sb[$];
    logic [31:0] m_rdata = '0;
    logic [15:0] m_txd = '0;
    logic [1:0]  m_txk = '0;
    logic        m_rphy = 1'b0;

    function automatic logic [31:0] status_word();
        return (32'(st_tx_ready) << 26) + (32'(st_rx_ready) << 25) + (32'(st_pll) << 24)
             + (32'(st_rd) << 22) + (32'(st_de) << 20) + (32'(st_ed) << 18)
             + (32'(st_dk) << 16) + 32'(st_rxd);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending transaction");
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
                    chk("rdata", rdata, e.rdata);
                    chk("sclk_edges", 32'(sl_cnt), 32'(e.edges));
                    chk("header", {24'h0, sl_hdr}, {24'h0, e.hdr});
                    chk("slave_tx", {13'h0, sl_rphy, sl_txk, sl_txd}, {13'h0, e.rphy, e.txk, e.txd});
                end
            end
        end
    end

    task automatic do_txn(input logic r, input logic [6:0] a, input logic [31:0] d,
                          input int hold, input bit poke);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        rw_i = r; addr_i = a; wdata_i = d; start = 1'b1;
        @(posedge clk); #1;
        if (r) begin
            if (a == 7'd1) begin
                m_txd  = 16'(d % 65536);
                m_txk  = 2'((d / 65536) % 4);
                m_rphy = (d / 262144) % 2 == 1;
            end
            e.lat   = 1 + D + 80 * D + D + CSI;
            e.edges = 40;
        end else begin
            m_rdata = (a == 7'd1) ? status_word() : 32'hFFFF_FFFF;
            e.lat   = 1 + D + 16 * D + G + 62 * D + D + CSI;
            e.edges = 39;
        end
        e.rdata = m_rdata;
        e.hdr   = 8'(r) * 8'd128 + 8'(a);
        e.txd = m_txd; e.txk = m_txk; e.rphy = m_rphy;
        e.t0  = cyc;
        sb.push_back(e);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            if (poke && n == 60) start = 1'b1;
            if (n == 61) start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (n >= 4000) begin
            checks++; errors++;
            $display("FAIL timeout: got busy after %0d cycles expected done", n);
        end
    endtask

    task automatic rand_status();
        st_tx_ready = 1'($urandom); st_rx_ready = 1'($urandom); st_pll = 1'($urandom);
        st_rd = 2'($urandom); st_de = 2'($urandom); st_ed = 2'($urandom); st_dk = 2'($urandom);
        st_rxd = 16'($urandom);
    endtask

    initial begin : stim
        int n;
        logic [6:0] a;
        // reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_cs", {31'h0, cs}, 32'h1);
        chk("rst_sclk", {31'h0, sclk}, 32'h0);
        chk("rst_mosi", {31'h0, mosi}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_cs", {31'h0, cs}, 32'h1);
        chk("idle_sclk_busy", {30'h0, sclk, busy}, 32'h0);

        // directed write and reads
        do_txn(1'b1, 7'h01, 32'h0007_A5BC, 1, 0);
        chk("dir_txd", {13'h0, sl_rphy, sl_txk, sl_txd}, {13'h0, 1'b1, 2'b11, 16'hA5BC});
        st_tx_ready = 1; st_rx_ready = 1; st_pll = 1; st_rxd = 16'h1234;
        do_txn(1'b0, 7'h01, 32'h0, 1, 0);
        chk("dir_read", rdata, 32'h0700_1234);
        do_txn(1'b0, 7'h05, 32'h0, 1, 0);
        chk("dir_unaddr", rdata, 32'hFFFF_FFFF);

        // start held 3 cycles plus a start pulse while busy -> one transaction
        do_txn(1'b1, 7'h01, 32'h0003_1111, 3, 1);

        // abort during write data
        @(posedge clk); #1;
        rw_i = 1'b1; addr_i = 7'h01; wdata_i = 32'h0004_DEAD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (sl_cnt != 18 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL abort_wait: got %0d edges expected 18", sl_cnt);
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_cs", {31'h0, cs}, 32'h1);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        m_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_tx_kept", {13'h0, sl_rphy, sl_txk, sl_txd}, {13'h0, m_rphy, m_txk, m_txd});
        do_txn(1'b1, 7'h01, 32'h0002_5A5A, 1, 0);

        // randomized traffic
        for (int k = 0; k < 8; k++) begin
            a = ($urandom_range(0, 1) == 0) ? 7'h01 : 7'($urandom);
            rand_status();
            do_txn(1'($urandom), a, $urandom, 1, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
